ps2_host_tx: RTL and testbench
==============================

Name: ps2_host_tx

Overview:
- PS/2 host-to-device transmitter; the counterpart of the keyboard receive path.
- Sends one command byte to the keyboard, e.g. 8'hFF reset, 8'hF4 enable, 8'hED set-LED.
- Drives the open-drain PS2_CLK/PS2_DATA lines through separate enables; the top level builds the tristates.
- Raises tx_active so the receive path ignores bus activity while a frame is in flight.

Parameters:
- INHIBIT_CYCLES, 10000, cycles PS2_CLK is held low before request-to-send (100 us at 100 MHz).
- RTS_CYCLES, 200, cycles both lines are held low before PS2_CLK is released.
- TIMEOUT_CYCLES, 2000000, maximum cycles between device clock falling edges (20 ms).

Ports:
- clk  in  1  system clock, 100 MHz
- rst  in  1  asynchronous, active-low reset
- tx_valid  in  1  request to send tx_data
- tx_data  in  8  command byte
- tx_ready  out  1  high only in IDLE; a byte is accepted when tx_valid && tx_ready
- tx_active  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse: frame sent and acknowledged
- err  out  1  one-cycle pulse: NACK or timeout
- ps2_clk_in  in  1  raw PS2_CLK line level
- ps2_data_in  in  1  raw PS2_DATA line level
- ps2_clk_oe  out  1  1 = pull PS2_CLK low
- ps2_data_oe  out  1  1 = pull PS2_DATA low

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-frame): state IDLE, tx_ready=1, tx_active=0, done=0, err=0, ps2_clk_oe=0, ps2_data_oe=0, all counters cleared.
- Input sampling: ps2_clk_in and ps2_data_in pass through 2-flop synchronizers.
- Falling-edge strobe fe = previous synchronized clk AND NOT current synchronized clk; fe lags the pin by 3 cycles.
- On accept, latch shreg = {stop=1, parity=~^tx_data, tx_data}; parity is odd.
- FSM:
  - IDLE: accept -> INHIBIT.
  - INHIBIT: clk_oe=1 for INHIBIT_CYCLES -> RTS.
  - RTS: clk_oe=1 and data_oe=1 (start bit 0) for RTS_CYCLES; then clk_oe=0 -> SEND with bitcnt=0. data_oe stays 1.
  - SEND: on each fe, data_oe <= ~shreg[bitcnt] and bitcnt++. Order is data bits 0..7 LSB first, parity, stop (stop releases the line). After the 10th fe -> ACK.
  - ACK: on the next fe (the 11th), sample synchronized data. 0 -> WAIT_IDLE. 1 -> err pulse, IDLE.
  - WAIT_IDLE: wait until synchronized clk and data are both 1, then done pulse -> IDLE.
- Timeout: a counter clears on every fe and on entering SEND. In SEND, ACK and WAIT_IDLE, reaching TIMEOUT_CYCLES gives err pulse, both oe=0, state IDLE.
- done and err never assert in the same cycle.
- tx_valid outside IDLE is ignored; there is no queuing.
- The only line that may be driven low in IDLE is none: both oe are 0.
- All outputs are registered.

Decomposition:
- Shared package ps2_pkg holds:
  - FSM state encodings: IDLE, INHIBIT, RTS, SEND, ACK, WAIT_IDLE.
  - Command constants: CMD_RESET=8'hFF, CMD_ENABLE=8'hF4, CMD_SET_LED=8'hED, RESP_ACK=8'hFA.
  - Frame length constant FRAME_FE=11.
- Sub-module ps2_line_sync: the synchronizers plus the fe strobe, reusable by the receiver.

Test Plan:
- Send 8'hED; the device model clocks at 12.5 kHz and ACKs on the 11th fe.
  - Expect clk_oe high exactly 10000+200 cycles.
  - Expect line sequence after start bit 0: 1,0,1,1,0,1,1,1, parity 1, stop 1.
  - Expect done pulse once lines idle; tx_ready returns to 1.
- Send 8'hF4 -> data bits 0,0,1,0,1,1,1,1 and parity 0; done asserted, err stays 0.
- Device leaves data high at the 11th fe (NACK) -> err pulse, no done, both oe=0, IDLE.
- Device never clocks after RTS -> err exactly TIMEOUT_CYCLES after clk_oe falls; lines released.
- tx_valid with 8'h00 pulsed during SEND of 8'hFF -> ignored; only the 8'hFF frame appears on the bus.
- Assert rst after the 5th fe -> both oe drop to 0 in the same cycle; state IDLE, tx_ready=1. A following 8'hF4 frame completes normally.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 host blocks.
//   - ps2_state_e : host transmit FSM states
//   - CMD_* / RESP_ACK : common keyboard command and response bytes
//   - FRAME_FE : device clock falling edges per host-to-device frame
//                (10 data/parity/stop edges plus the acknowledge edge)
//   - odd_parity() : parity bit that makes the 9-bit data+parity word odd
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    RTS,
    SEND,
    ACK,
    WAIT_IDLE
  } ps2_state_e;

  localparam logic [7:0] CMD_RESET   = 8'hFF;
  localparam logic [7:0] CMD_ENABLE  = 8'hF4;
  localparam logic [7:0] CMD_SET_LED = 8'hED;
  localparam logic [7:0] RESP_ACK    = 8'hFA;

  localparam int FRAME_FE = 11;

  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizers for the raw PS/2 clock and data lines plus a
// registered falling-edge strobe on the synchronized clock.
//   clk, rst     : system clock, asynchronous active-low reset
//   clk_in       : raw PS2_CLK level
//   data_in      : raw PS2_DATA level
//   clk_s/data_s : synchronized line levels (2-cycle lag)
//   fe           : one-cycle strobe, PS2_CLK fell (3-cycle lag from pin)
module ps2_line_sync (
  input  logic clk,
  input  logic rst,
  input  logic clk_in,
  input  logic data_in,
  output logic clk_s,
  output logic data_s,
  output logic fe
);

  logic [1:0] clk_sync_q, clk_sync_d;
  logic [1:0] data_sync_q, data_sync_d;
  logic       clk_prev_q, clk_prev_d;
  logic       fe_q, fe_d;

  always_comb begin
    clk_sync_d  = {clk_sync_q[0], clk_in};
    data_sync_d = {data_sync_q[0], data_in};
    clk_prev_d  = clk_sync_q[1];
    fe_d        = clk_prev_q & ~clk_sync_q[1];
  end

  // Idle bus is high, so the synchronizers reset to 1 to avoid a
  // spurious edge right after reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
      clk_prev_q  <= 1'b1;
      fe_q        <= 1'b0;
    end else begin
      clk_sync_q  <= clk_sync_d;
      data_sync_q <= data_sync_d;
      clk_prev_q  <= clk_prev_d;
      fe_q        <= fe_d;
    end
  end

  assign clk_s  = clk_sync_q[1];
  assign data_s = data_sync_q[1];
  assign fe     = fe_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter. Sends one command byte to the device:
// inhibits the bus, issues request-to-send, then shifts data/parity/stop
// out on device clock falling edges and checks the device acknowledge.
//   clk, rst               : system clock, asynchronous active-low reset
//   tx_valid/tx_data       : byte request, accepted when tx_ready is high
//   tx_ready               : high only while idle
//   tx_active              : high while a frame is in flight
//   done / err             : one-cycle pulses, ACKed frame / NACK or timeout
//   ps2_clk_in/ps2_data_in : raw line levels
//   ps2_clk_oe/ps2_data_oe : 1 pulls the corresponding line low
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 10000,
  parameter int RTS_CYCLES     = 200,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       tx_active,
  output logic       done,
  output logic       err,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  localparam int MAXC = (TIMEOUT_CYCLES > INHIBIT_CYCLES)
                        ? ((TIMEOUT_CYCLES > RTS_CYCLES) ? TIMEOUT_CYCLES : RTS_CYCLES)
                        : ((INHIBIT_CYCLES > RTS_CYCLES) ? INHIBIT_CYCLES : RTS_CYCLES);
  localparam int CW = $clog2(MAXC + 1);

  logic clk_s, data_s, fe;

  ps2_line_sync u_sync (
    .clk     (clk),
    .rst     (rst),
    .clk_in  (ps2_clk_in),
    .data_in (ps2_data_in),
    .clk_s   (clk_s),
    .data_s  (data_s),
    .fe      (fe)
  );

  ps2_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    bitcnt_q, bitcnt_d;
  logic [9:0]    shreg_q, shreg_d;
  logic          clk_oe_q, clk_oe_d;
  logic          data_oe_q, data_oe_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          ready_q, ready_d;
  logic          active_q, active_d;
  logic          timeout;

  // cnt_q doubles as phase timer (INHIBIT/RTS) and edge-gap watchdog.
  assign timeout = (cnt_q == CW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + CW'(1);
    bitcnt_d  = bitcnt_q;
    shreg_d   = shreg_q;
    clk_oe_d  = clk_oe_q;
    data_oe_d = data_oe_q;
    done_d    = 1'b0;
    err_d     = 1'b0;

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (tx_valid && ready_q) begin
          shreg_d  = {1'b1, odd_parity(tx_data), tx_data};
          clk_oe_d = 1'b1;
          state_d  = INHIBIT;
        end
      end
      INHIBIT: begin
        if (cnt_q == CW'(INHIBIT_CYCLES - 1)) begin
          cnt_d     = '0;
          data_oe_d = 1'b1;  // start bit
          state_d   = RTS;
        end
      end
      RTS: begin
        if (cnt_q == CW'(RTS_CYCLES - 1)) begin
          cnt_d    = '0;
          bitcnt_d = '0;
          clk_oe_d = 1'b0;   // hand the clock to the device
          state_d  = SEND;
        end
      end
      SEND: begin
        if (fe) begin
          data_oe_d = ~shreg_q[bitcnt_q];
          bitcnt_d  = bitcnt_q + 4'd1;
          cnt_d     = '0;
          if (bitcnt_q == 4'(FRAME_FE - 2)) state_d = ACK;
        end else if (timeout) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
      ACK: begin
        if (fe) begin
          cnt_d = '0;
          if (!data_s) begin
            state_d = WAIT_IDLE;
          end else begin
            err_d   = 1'b1;
            state_d = IDLE;
          end
        end else if (timeout) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
      WAIT_IDLE: begin
        if (clk_s && data_s) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end else if (fe) begin
          cnt_d = '0;
        end else if (timeout) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Never leave a line pulled low once back in IDLE.
    if (state_d == IDLE) begin
      clk_oe_d  = 1'b0;
      data_oe_d = 1'b0;
    end
    ready_d  = (state_d == IDLE);
    active_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bitcnt_q  <= '0;
      shreg_q   <= '0;
      clk_oe_q  <= 1'b0;
      data_oe_q <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      ready_q   <= 1'b1;
      active_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bitcnt_q  <= bitcnt_d;
      shreg_q   <= shreg_d;
      clk_oe_q  <= clk_oe_d;
      data_oe_q <= data_oe_d;
      done_q    <= done_d;
      err_q     <= err_d;
      ready_q   <= ready_d;
      active_q  <= active_d;
    end
  end

  assign tx_ready    = ready_q;
  assign tx_active   = active_q;
  assign done        = done_q;
  assign err         = err_q;
  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a behavioural PS/2 device clocks frames out of
// the host; expected frames are queued when a byte is sent and compared
// against what the device captured on the wire.
module tb_ps2_host_tx;

  localparam int INH  = 100;
  localparam int RTSC = 20;
  localparam int TO   = 300;
  localparam int H    = 15;   // device clock half period in system cycles

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_ready, tx_active, done, err;
  logic       ps2_clk_in, ps2_data_in, ps2_clk_oe, ps2_data_oe;
  logic       dev_clk = 1'b1;
  logic       dev_data = 1'b1;

  // Open-drain wired-AND of host and device.
  assign ps2_clk_in  = dev_clk & ~ps2_clk_oe;
  assign ps2_data_in = dev_data & ~ps2_data_oe;

  ps2_host_tx #(
    .INHIBIT_CYCLES (INH),
    .RTS_CYCLES     (RTSC),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .tx_valid    (tx_valid),
    .tx_data     (tx_data),
    .tx_ready    (tx_ready),
    .tx_active   (tx_active),
    .done        (done),
    .err         (err),
    .ps2_clk_in  (ps2_clk_in),
    .ps2_data_in (ps2_data_in),
    .ps2_clk_oe  (ps2_clk_oe),
    .ps2_data_oe (ps2_data_oe)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int done_cnt = 0, err_cnt = 0, both_cnt = 0;
  logic [9:0] exp_q[$];

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (err) err_cnt++;
    if (done && err) both_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Request a byte, then measure how long the host holds the clock low.
  task automatic send_byte(input logic [7:0] d, input logic [9:0] frame, input bit push);
    int hi;
    if (push) exp_q.push_back(frame);
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    chk("busy_ready", tx_ready, 0);
    chk("busy_active", tx_active, 1);
    hi = 0;
    while (ps2_clk_oe && hi < INH + RTSC + 50) begin
      hi++;
      @(negedge clk);
    end
    chk("clk_oe_len", hi, INH + RTSC);
    chk("start_bit", ps2_data_in, 0);
  endtask

  // Device side: 10 falling edges capturing each bit on the rising edge,
  // then the acknowledge edge. stop_after>0 aborts just after that edge.
  task automatic device(input bit ack, input int stop_after);
    logic [9:0] cap;
    logic [9:0] e;
    cap = '0;
    cyc(H);
    for (int i = 1; i <= 10; i++) begin
      dev_clk = 1'b0;
      if (i == stop_after) begin
        cyc(5);
        if (exp_q.size() != 0) e = exp_q.pop_front();
        return;
      end
      cyc(H);
      dev_clk = 1'b1;
      cap[i-1] = ps2_data_in;
      cyc(H);
    end
    if (ack) dev_data = 1'b0;
    cyc(4);
    dev_clk = 1'b0;
    cyc(H);
    dev_clk  = 1'b1;
    dev_data = 1'b1;
    chk("sb_nonempty", exp_q.size() != 0, 1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("frame", cap, e);
    end
  endtask

  task automatic finish_frame(input int d0, input int e0, input int exp_done, input int exp_err);
    int w;
    w = 0;
    while (done_cnt == d0 && err_cnt == e0 && w < 100) begin
      w++;
      @(negedge clk);
    end
    cyc(3);
    chk("done_cnt", done_cnt - d0, exp_done);
    chk("err_cnt", err_cnt - e0, exp_err);
    chk("idle_clk_oe", ps2_clk_oe, 0);
    chk("idle_data_oe", ps2_data_oe, 0);
    chk("idle_ready", tx_ready, 1);
  endtask

  initial begin
    int d0, e0, k, hits;

    // Reset state
    cyc(3);
    chk("rst_ready", tx_ready, 1);
    chk("rst_active", tx_active, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_oe", {ps2_clk_oe, ps2_data_oe}, 0);
    rst = 1'b1;
    cyc(3);

    // Set-LED: bits 1,0,1,1,0,1,1,1, parity 1, stop 1
    d0 = done_cnt; e0 = err_cnt;
    send_byte(8'hED, 10'b11_1110_1101, 1'b1);
    device(1'b1, 0);
    finish_frame(d0, e0, 1, 0);

    // Enable: bits 0,0,1,0,1,1,1,1, parity 0
    d0 = done_cnt; e0 = err_cnt;
    send_byte(8'hF4, 10'b10_1111_0100, 1'b1);
    device(1'b1, 0);
    finish_frame(d0, e0, 1, 0);

    // NACK: device leaves data high on the 11th edge
    d0 = done_cnt; e0 = err_cnt;
    send_byte(8'hFF, 10'b11_1111_1111, 1'b1);
    device(1'b0, 0);
    finish_frame(d0, e0, 0, 1);

    // Timeout: device never clocks
    e0 = err_cnt;
    send_byte(8'hF4, 10'b10_1111_0100, 1'b0);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!err && k < TO + 50);
    chk("timeout_len", k, TO);
    chk("timeout_oe", {ps2_clk_oe, ps2_data_oe}, 0);
    cyc(2);
    chk("timeout_ready", tx_ready, 1);

    // Spurious request during SEND is dropped
    d0 = done_cnt; e0 = err_cnt;
    send_byte(8'hFF, 10'b11_1111_1111, 1'b1);
    fork
      device(1'b1, 0);
      begin
        cyc(H * 4);
        tx_data  = 8'h00;
        tx_valid = 1'b1;
        cyc(1);
        tx_valid = 1'b0;
      end
    join
    finish_frame(d0, e0, 1, 0);
    hits = 0;
    for (int i = 0; i < INH / 2; i++) begin
      if (ps2_clk_oe) hits++;
      @(negedge clk);
    end
    chk("no_extra_frame", hits, 0);
    chk("sb_empty", exp_q.size(), 0);

    // Reset after the 5th falling edge
    send_byte(8'hF4, 10'b10_1111_0100, 1'b1);
    device(1'b1, 5);
    rst = 1'b0;
    #1;
    chk("midrst_oe", {ps2_clk_oe, ps2_data_oe}, 0);
    chk("midrst_ready", tx_ready, 1);
    chk("midrst_active", tx_active, 0);
    dev_clk  = 1'b1;
    dev_data = 1'b1;
    cyc(3);
    rst = 1'b1;
    cyc(3);
    d0 = done_cnt; e0 = err_cnt;
    send_byte(8'hF4, 10'b10_1111_0100, 1'b1);
    device(1'b1, 0);
    finish_frame(d0, e0, 1, 0);

    chk("done_err_overlap", both_cnt, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
